// File: rtl/dp_ram_be.sv
// Dual-port byte-enable RAM: port A fetch reads, port B loads/stores, with a
// post-reset clear sequencer, registered read-valid handshake and top-word tap.
module dp_ram_be #(
  parameter int ADDR_W         = 9,
  parameter int NUM_BYTES      = 4,
  localparam int DATA_W        = 8 * NUM_BYTES,
  parameter logic [DATA_W-1:0] RESET_WORD = 32'h00000013,
  parameter bit OUT_REG        = 1'b0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_req,
  input  logic [31:0]          a_addr,
  output logic [DATA_W-1:0]    a_rdata,
  output logic                 a_rvalid,
  output logic                 a_err,
  input  logic                 b_req,
  input  logic [NUM_BYTES-1:0] b_we,
  input  logic [31:0]          b_addr,
  input  logic [DATA_W-1:0]    b_wdata,
  output logic [DATA_W-1:0]    b_rdata,
  output logic                 b_rvalid,
  output logic                 b_err,
  output logic                 b_wack,
  output logic                 ready,
  output logic [DATA_W-1:0]    top_word
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] a_idx, b_idx;
  logic              a_in_range, b_in_range;
  logic              a_acc, b_acc, b_is_wr, b_wr_en, clearing, clr_last;
  logic [DATA_W-1:0] top_merged;

  logic              a_v1, a_err1, b_v1, b_wack1, b_err1;
  logic [DATA_W-1:0] a_rdata1, b_rdata1;

  logic              unused_addr_bits;

  assign a_idx      = a_addr[ADDR_W+1:2];
  assign b_idx      = b_addr[ADDR_W+1:2];
  assign a_in_range = (a_addr[31:ADDR_W+2] == '0);
  assign b_in_range = (b_addr[31:ADDR_W+2] == '0);
  assign unused_addr_bits = ^{a_addr[1:0], b_addr[1:0]};

  assign ready    = (state_q == ST_READY);
  assign clearing = (state_q == ST_CLEAR);
  assign clr_last = &clr_cnt;
  assign a_acc    = a_req & ready;
  assign b_acc    = b_req & ready;
  assign b_is_wr  = |b_we;
  assign b_wr_en  = b_acc & b_is_wr & b_in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (clearing) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_last) state_d = ST_READY;
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_READY;
    endcase
  end

  // Contents are left alone in the reset cycle; the clear sequencer zeroes them afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clearing) begin
        mem[clr_cnt] <= '0;
      end else if (b_wr_en) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (b_we[i]) mem[b_idx][8*i +: 8] <= b_wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    top_merged = mem[DEPTH-1];
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (b_we[i]) top_merged[8*i +: 8] = b_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top_word <= '0;
    end else if (clearing) begin
      if (clr_last) top_word <= '0;
    end else if (b_wr_en && (&b_idx)) begin
      top_word <= top_merged;
    end
  end

  // First read stage; reading mem here while the write block updates it gives read-first collisions.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rdata1 <= RESET_WORD;
      a_v1     <= 1'b0;
      a_err1   <= 1'b0;
      b_rdata1 <= RESET_WORD;
      b_v1     <= 1'b0;
      b_wack1  <= 1'b0;
      b_err1   <= 1'b0;
    end else begin
      a_v1    <= a_acc;
      a_err1  <= a_acc & ~a_in_range;
      b_v1    <= b_acc & ~b_is_wr;
      b_wack1 <= b_acc & b_is_wr;
      b_err1  <= b_acc & ~b_in_range;
      if (a_acc) a_rdata1 <= a_in_range ? mem[a_idx] : '0;
      if (b_acc && !b_is_wr) b_rdata1 <= b_in_range ? mem[b_idx] : '0;
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      always_ff @(posedge clk) begin
        if (reset) begin
          a_rdata  <= RESET_WORD;
          a_rvalid <= 1'b0;
          a_err    <= 1'b0;
          b_rdata  <= RESET_WORD;
          b_rvalid <= 1'b0;
          b_wack   <= 1'b0;
          b_err    <= 1'b0;
        end else begin
          a_rvalid <= a_v1;
          a_err    <= a_err1;
          b_rvalid <= b_v1;
          b_wack   <= b_wack1;
          b_err    <= b_err1;
          if (a_v1) a_rdata <= a_rdata1;
          if (b_v1) b_rdata <= b_rdata1;
        end
      end
    end else begin : g_no_out_reg
      assign a_rdata  = a_rdata1;
      assign a_rvalid = a_v1;
      assign a_err    = a_err1;
      assign b_rdata  = b_rdata1;
      assign b_rvalid = b_v1;
      assign b_wack   = b_wack1;
      assign b_err    = b_err1;
    end
  endgenerate

endmodule

// File: tb/tb_dp_ram_be.sv
// Bench for dp_ram_be: two instances (OUT_REG 0 and 1) share stimulus and are
// checked every cycle against an array-based reference memory.
module tb_dp_ram_be;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset, a_req, b_req;
  logic [31:0] a_addr, b_addr, b_wdata;
  logic [3:0]  b_we;

  logic [31:0] a_rdata0, b_rdata0, top0, a_rdata1, b_rdata1, top1;
  logic        a_rvalid0, a_err0, b_rvalid0, b_err0, b_wack0, ready0;
  logic        a_rvalid1, a_err1, b_rvalid1, b_err1, b_wack1, ready1;

  always #5 clk = ~clk;

  dp_ram_be #(.ADDR_W(ADDR_W), .NUM_BYTES(4), .RESET_WORD(NOP), .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b1)) dut0 (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_rdata(a_rdata0), .a_rvalid(a_rvalid0), .a_err(a_err0),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata0), .b_rvalid(b_rvalid0), .b_err(b_err0), .b_wack(b_wack0),
    .ready(ready0), .top_word(top0)
  );

  dp_ram_be #(.ADDR_W(ADDR_W), .NUM_BYTES(4), .RESET_WORD(NOP), .OUT_REG(1'b1), .CLEAR_ON_RESET(1'b1)) dut1 (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_rdata(a_rdata1), .a_rvalid(a_rvalid1), .a_err(a_err1),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata1), .b_rvalid(b_rvalid1), .b_err(b_err1), .b_wack(b_wack1),
    .ready(ready1), .top_word(top1)
  );

  typedef struct packed {
    logic        av;
    logic [31:0] ad;
    logic        ae;
    logic        bv;
    logic [31:0] bd;
    logic        bw;
    logic        be;
  } resp_t;

  logic [31:0] ref_mem [DEPTH];
  int          clear_left = 0;
  logic        ref_ready = 1'b0;
  resp_t       r_now = '0, r_prev = '0;
  logic [31:0] ea0 = NOP, eb0 = NOP, ea1 = NOP, eb1 = NOP, etop = '0;
  int          compared = 0;
  int          mismatched = 0;

  function automatic bit inRange(logic [31:0] a);
    return a[31:ADDR_W+2] == '0;
  endfunction

  function automatic int wordIdx(logic [31:0] a);
    return int'(a[ADDR_W+1:2]);
  endfunction

  function automatic logic [31:0] pickAddr();
    logic [31:0] lo;
    int unsigned sel;
    lo  = 32'($urandom_range(0, 3));
    sel = $urandom_range(0, 7);
    case (sel)
      5:       return 32'h7FC | lo;
      6:       return (32'($urandom_range(0, DEPTH - 1)) << 2) | lo;
      7:       return $urandom | 32'h800;
      default: return (32'($urandom_range(0, 15)) << 2) | lo;
    endcase
  endfunction

  // Reference behaviour for one clock edge, using the inputs presented at that edge.
  task automatic modelEdge();
    resp_t       r;
    logic [31:0] merged;
    int          w;
    r = '0;
    if (reset) begin
      clear_left = DEPTH;
      ref_ready  = 1'b0;
      r_now  = '0;
      r_prev = '0;
      ea0 = NOP; eb0 = NOP; ea1 = NOP; eb1 = NOP;
      etop = '0;
    end else begin
      if (ref_ready) begin
        if (a_req) begin
          r.av = 1'b1;
          r.ae = !inRange(a_addr);
          r.ad = r.ae ? 32'h0 : ref_mem[wordIdx(a_addr)];
        end
        if (b_req) begin
          r.be = !inRange(b_addr);
          if (b_we == 4'b0000) begin
            r.bv = 1'b1;
            r.bd = r.be ? 32'h0 : ref_mem[wordIdx(b_addr)];
          end else begin
            r.bw = 1'b1;
            if (!r.be) begin
              w = wordIdx(b_addr);
              merged = ref_mem[w];
              for (int i = 0; i < 4; i++)
                if (b_we[i]) merged[8*i +: 8] = b_wdata[8*i +: 8];
              ref_mem[w] = merged;
              if (w == DEPTH - 1) etop = merged;
            end
          end
        end
      end else if (clear_left > 0) begin
        ref_mem[DEPTH - clear_left] = 32'h0;
        if (clear_left == 1) etop = 32'h0;
        clear_left--;
        if (clear_left == 0) ref_ready = 1'b1;
      end
      r_prev = r_now;
      r_now  = r;
      if (r_now.av)  ea0 = r_now.ad;
      if (r_now.bv)  eb0 = r_now.bd;
      if (r_prev.av) ea1 = r_prev.ad;
      if (r_prev.bv) eb1 = r_prev.bd;
    end
  endtask

  task automatic cmp32(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic cmp1(input string tag, input logic observed, input logic expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    cmp1 ("ready0",    ready0,    ref_ready);
    cmp1 ("ready1",    ready1,    ref_ready);
    cmp1 ("a_rvalid0", a_rvalid0, r_now.av);
    cmp1 ("a_err0",    a_err0,    r_now.ae);
    cmp32("a_rdata0",  a_rdata0,  ea0);
    cmp1 ("b_rvalid0", b_rvalid0, r_now.bv);
    cmp1 ("b_wack0",   b_wack0,   r_now.bw);
    cmp1 ("b_err0",    b_err0,    r_now.be);
    cmp32("b_rdata0",  b_rdata0,  eb0);
    cmp32("top0",      top0,      etop);
    cmp1 ("a_rvalid1", a_rvalid1, r_prev.av);
    cmp1 ("a_err1",    a_err1,    r_prev.ae);
    cmp32("a_rdata1",  a_rdata1,  ea1);
    cmp1 ("b_rvalid1", b_rvalid1, r_prev.bv);
    cmp1 ("b_wack1",   b_wack1,   r_prev.bw);
    cmp1 ("b_err1",    b_err1,    r_prev.be);
    cmp32("b_rdata1",  b_rdata1,  eb1);
    cmp32("top1",      top1,      etop);
  endtask

  task automatic applyStimulus(input logic rst, input logic ar, input logic [31:0] aa,
                               input logic br, input logic [3:0] bw, input logic [31:0] ba,
                               input logic [31:0] bd);
    reset   = rst;
    a_req   = ar;
    a_addr  = aa;
    b_req   = br;
    b_we    = bw;
    b_addr  = ba;
    b_wdata = bd;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic       ar, br;
    logic [3:0] bw;

    // Reset, then a full clear with requests (including a write) that must be ignored.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    cmp32("reset_a_rdata", a_rdata0, NOP);
    for (int c = 0; c < DEPTH; c++) begin
      cmp1("ready_low_in_clear", ready0, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'h10, 1'b1, 4'hF, 32'h10, 32'hFFFFFFFF);
    end
    cmp1("ready_after_clear", ready0, 1'b1);

    applyStimulus(1'b0, 1'b1, 32'h7FC, 1'b0, 4'h0, 32'h0, 32'h0);
    cmp1 ("top_read_valid", a_rvalid0, 1'b1);
    cmp32("top_read_zero", a_rdata0, 32'h0);

    // Byte-enable merge.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 4'b0010, 32'h10, 32'h00005500);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 4'b0000, 32'h10, 32'h0);
    cmp1 ("merge_rvalid", b_rvalid0, 1'b1);
    cmp32("merge_data", b_rdata0, 32'hDEAD55EF);

    // Read-first collision.
    applyStimulus(1'b0, 1'b1, 32'h20, 1'b1, 4'hF, 32'h20, 32'h12345678);
    cmp32("collide_old", a_rdata0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h20, 1'b0, 4'h0, 32'h0, 32'h0);
    cmp32("collide_new", a_rdata0, 32'h12345678);

    // Out-of-range accesses.
    applyStimulus(1'b0, 1'b1, 32'h800, 1'b0, 4'h0, 32'h0, 32'h0);
    cmp1 ("oor_a_err", a_err0, 1'b1);
    cmp32("oor_a_data", a_rdata0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 4'hF, 32'h800, 32'hCAFEF00D);
    cmp1("oor_b_err", b_err0, 1'b1);
    cmp1("oor_b_wack", b_wack0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    cmp32("oor_word0_kept", a_rdata0, 32'h0);

    // Back-to-back reads through the registered-output instance.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 4'hF, 32'h0, 32'h11110000);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 4'hF, 32'h4, 32'h22220004);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 4'hF, 32'h8, 32'h33330008);
    idle(2);
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    cmp1("pipe_lat_not_yet", a_rvalid1, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h4, 1'b0, 4'h0, 32'h0, 32'h0);
    cmp32("pipe_d0", a_rdata1, 32'h11110000);
    applyStimulus(1'b0, 1'b1, 32'h8, 1'b0, 4'h0, 32'h0, 32'h0);
    cmp32("pipe_d1", a_rdata1, 32'h22220004);
    idle(1);
    cmp1 ("pipe_v2", a_rvalid1, 1'b1);
    cmp32("pipe_d2", a_rdata1, 32'h33330008);
    idle(1);
    cmp1("pipe_end", a_rvalid1, 1'b0);

    // Top-word tap.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 4'b0001, 32'h7FC, 32'hFFFFFFA5);
    cmp32("top_word0", top0, 32'h000000A5);
    cmp1 ("top_wack0", b_wack0, 1'b1);
    idle(1);
    cmp32("top_word1", top1, 32'h000000A5);
    cmp1 ("top_wack1", b_wack1, 1'b1);

    $display("[TB] random phase");
    for (int n = 0; n < 400; n++) begin
      ar = 1'($urandom_range(0, 1));
      br = 1'($urandom_range(0, 1));
      bw = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      applyStimulus(1'b0, ar, pickAddr(), br, bw, pickAddr(), $urandom);
    end

    // Reset reasserted partway through a clear restarts the sequence.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (100) applyStimulus(1'b0, 1'b1, 32'h4, 1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int c = 0; c < DEPTH; c++) begin
      cmp1("ready_low_reclear", ready0, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'h4, 1'b0, 4'h0, 32'h0, 32'h0);
    end
    cmp1("ready_after_reclear", ready0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h4, 1'b1, 4'h0, 32'h7FC, 32'h0);
    cmp32("reclear_word1", a_rdata0, 32'h0);
    cmp32("reclear_top", b_rdata0, 32'h0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dp_ram_be.md
Name: dp_ram_be

Overview:
- Parametrised dual-port synchronous RAM for the core's unified instruction/data memory.
- Port A is the instruction-fetch read port. Port B is the load/store port, with true per-byte write enables.
- A multi-cycle clear sequencer replaces single-cycle whole-array reset.
- Provides a registered read-valid handshake, an optional output pipeline stage, address range checking, and a registered tap of the top word for MMIO (LED) use.

Parameters:
- ADDR_W, 9: word-address bits; DEPTH = 2**ADDR_W words.
- NUM_BYTES, 4: bytes per word; DATA_W = 8*NUM_BYTES.
- RESET_WORD, 32'h00000013: value driven on a_rdata/b_rdata after reset (RV32 NOP); width DATA_W.
- OUT_REG, 0: 1 = extra output register stage on both read ports.
- CLEAR_ON_RESET, 1: 1 = zero the array after reset via the clear sequencer; 0 = contents untouched, ready immediately.

Ports:
- clk  in  1  clock, all logic posedge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  port A read request.
- a_addr  in  32  port A byte address.
- a_rdata  out  DATA_W  port A read data.
- a_rvalid  out  1  a_rdata valid pulse.
- a_err  out  1  registered out-of-range flag, aligned with a_rvalid.
- b_req  in  1  port B request.
- b_we  in  NUM_BYTES  byte write enables; nonzero = write, zero = read.
- b_addr  in  32  port B byte address.
- b_wdata  in  DATA_W  write data.
- b_rdata  out  DATA_W  port B read data.
- b_rvalid  out  1  b_rdata valid pulse (reads only).
- b_err  out  1  registered out-of-range flag, aligned with b_rvalid/write ack.
- b_wack  out  1  write accepted pulse.
- ready  out  1  1 = requests accepted; 0 while clearing.
- top_word  out  DATA_W  registered copy of mem[DEPTH-1].

Behaviour:
- Addressing:
  - Word index = addr[ADDR_W+1:2]; addr[1:0] is ignored.
  - In range iff addr[31:ADDR_W+2] == 0.
- Reset, sampled on a clk edge with reset=1:
  - a_rdata = b_rdata = RESET_WORD.
  - a_rvalid = b_rvalid = b_wack = a_err = b_err = 0.
  - top_word = 0.
  - Clear counter = 0.
  - FSM -> CLEAR if CLEAR_ON_RESET, else READY.
  - Memory contents are not touched in the reset cycle itself.
- FSM CLEAR:
  - ready = 0. Each cycle mem[cnt] <= 0 and cnt++.
  - When cnt == DEPTH-1 is written, go to READY; total DEPTH cycles.
  - Requests during CLEAR are ignored: no rvalid, no wack, no write.
  - reset asserted mid-CLEAR restarts cnt at 0.
- FSM READY: ready = 1; stays until reset.
- Port A read:
  - A request is accepted when a_req & ready.
  - With OUT_REG = 0, a_rdata and a_rvalid appear on the next edge (latency 1); with OUT_REG = 1, latency is 2.
  - a_rvalid is a one-cycle pulse per accepted request. Back-to-back requests give back-to-back pulses; full throughput.
  - Out of range: a_rdata = 0, a_err = 1 with a_rvalid.
  - a_rdata holds its last value when no request is accepted.
- Port B read (b_we == 0): same timing and error rules as port A, using b_rdata, b_rvalid and b_err.
- Port B write (b_we != 0):
  - For each byte i with b_we[i]=1, byte i of mem[idx] <= b_wdata byte i; other bytes are preserved.
  - b_wack pulses with the same latency as a read. b_rvalid stays 0 and b_rdata holds its value.
  - Out of range: memory unchanged, b_err = 1 with b_wack.
- Same-address collisions:
  - A read vs B write, same word, same cycle: read-first; a_rdata returns the pre-write data. Next-cycle reads see the new data.
  - A and B both reading the same word is legal; both return the same data.
- top_word:
  - Updated on the same edge as any in-range B write to word DEPTH-1, using the merged byte result.
  - Cleared to 0 at reset; it must match mem[DEPTH-1] after CLEAR.
- Widths: all byte merging is DATA_W wide. No sign or zero extension is done here; the load unit does it.

Test Plan:
- Reset one cycle with defaults -> ready = 0 for exactly 512 cycles, then 1. a_rdata = 32'h00000013 and rvalid = 0 throughout. A read of 0x7FC after ready returns 0.
- B write 0xDEADBEEF, b_we = 4'b1111 @0x10; then b_we = 4'b0010, wdata 0x00005500 @0x10; read @0x10 -> 0xDEAD55EF, b_rvalid one cycle after req.
- Same cycle: B write 0x12345678 @0x20 and A read @0x20 (old 0) -> a_rdata = 0; A read next cycle -> 0x12345678.
- A read 0x800 (out of range, ADDR_W=9) -> a_rdata = 0, a_err = 1 with a_rvalid. B write 0x800 -> b_err = 1, b_wack = 1, word 0 unchanged.
- OUT_REG = 1, A reads on 3 consecutive cycles to 0x0, 0x4, 0x8 -> three consecutive rvalid pulses starting 2 cycles after first req, data in order. Write 0xA5 byte0 @0x7FC -> top_word = 0x000000A5 same edge as wack.
- reset reasserted at clear cycle 100 -> ready stays 0 for a further 512 cycles after reset drops. a_req during CLEAR -> no a_rvalid.
